// File: rtl/text_pkg.sv
// Shared text-rendering definitions: blitter FSM states, default geometry
// and the glyph bit pattern used to populate the glyph ROM.
package text_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAW,
    DONE
  } blit_state_t;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_CHAR_WIDTH    = 20;
  localparam int DEF_CHAR_HEIGHT   = 30;
  localparam int DEF_ORIGIN_Y      = 270;
  localparam int DEF_PIXEL_BITS    = 3;
  localparam int DEF_ADDR_BITS     = 19;

  // Procedural glyph set: pixel (px,py) of glyph 'code' takes one bit of the
  // code itself, so glyph 0 is blank and 0xFF is solid.
  function automatic logic glyph_pixel(input logic [7:0] code, input int px, input int py);
    logic [2:0] sel;
    sel = 3'(px ^ py);
    return code[sel];
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// Glyph ROM: one CHAR_WIDTH*CHAR_HEIGHT bitmap per 8-bit code, raster order
// with the top-left pixel in the MSB, read with one cycle of latency.
module glyph_rom
  import text_pkg::*;
#(
  parameter int CHAR_WIDTH  = DEF_CHAR_WIDTH,
  parameter int CHAR_HEIGHT = DEF_CHAR_HEIGHT
) (
  input  logic                              clock,
  input  logic [7:0]                        addr,
  output logic [CHAR_WIDTH*CHAR_HEIGHT-1:0] data
);

  localparam int GLYPH_BITS = CHAR_WIDTH * CHAR_HEIGHT;

  logic [GLYPH_BITS-1:0] pattern;

  // Shifting pixels in raster order leaves the first pixel in the MSB.
  always_comb begin
    pattern = '0;
    for (int py = 0; py < CHAR_HEIGHT; py++) begin
      for (int px = 0; px < CHAR_WIDTH; px++) begin
        pattern = {pattern[GLYPH_BITS-2:0], glyph_pixel(addr, px, py)};
      end
    end
  end

  always_ff @(posedge clock) begin
    data <= pattern;
  end

endmodule

// File: rtl/glyph_blitter.sv
// Glyph blitter: draws one glyph into the framebuffer, one pixel per cycle.
// Define GLYPH_TRANSPARENT_EN to skip writes for clear glyph bits.
module glyph_blitter
  import text_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int CHAR_WIDTH    = DEF_CHAR_WIDTH,
  parameter int CHAR_HEIGHT   = DEF_CHAR_HEIGHT,
  parameter int ORIGIN_Y      = DEF_ORIGIN_Y,
  parameter int PIXEL_BITS    = DEF_PIXEL_BITS,
  parameter int ADDR_BITS     = DEF_ADDR_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            row_num,
  input  logic [7:0]            col_num,
  input  logic [7:0]            char_code,
  input  logic [PIXEL_BITS-1:0] fg_color,
  input  logic [PIXEL_BITS-1:0] bg_color,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_BITS-1:0]  mem_waddr,
  output logic [PIXEL_BITS-1:0] mem_wdata,
  output logic                  mem_wenable
);

  localparam int GLYPH_BITS = CHAR_WIDTH * CHAR_HEIGHT;
  localparam int IDX_W      = $clog2(GLYPH_BITS);
  localparam int PX_W       = $clog2(CHAR_WIDTH + 1);
  localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(SCREEN_WIDTH - CHAR_WIDTH + 1);

  blit_state_t state, state_next;

  logic [7:0]            row_q, col_q, char_q;
  logic [PIXEL_BITS-1:0] fg_q, bg_q;
  logic [PX_W-1:0]       px;
  logic [IDX_W-1:0]      bit_idx;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [GLYPH_BITS-1:0] glyph;
  logic                  error_q;
  logic                  in_bounds, accept, line_end, last_pixel, pixel_on;

  glyph_rom #(
    .CHAR_WIDTH (CHAR_WIDTH),
    .CHAR_HEIGHT(CHAR_HEIGHT)
  ) u_rom (
    .clock(clock),
    .addr (char_q),
    .data (glyph)
  );

  assign in_bounds  = (int'(col_num) * CHAR_WIDTH + CHAR_WIDTH <= SCREEN_WIDTH) &&
                      (ORIGIN_Y + (int'(row_num) + 1) * CHAR_HEIGHT <= SCREEN_HEIGHT);
  assign accept     = (state == IDLE) && start && in_bounds;
  assign line_end   = (px == PX_W'(CHAR_WIDTH - 1));
  assign last_pixel = (bit_idx == '0);
  assign pixel_on   = glyph[bit_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = FETCH;
      FETCH:   state_next = DRAW;
      DRAW:    if (last_pixel) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The one multiply-based base address is formed during FETCH while the ROM
  // read is in flight; DRAW only ever adds 1 or the line step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      char_q  <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      px      <= '0;
      bit_idx <= '0;
      addr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= (state == IDLE) && start && !in_bounds;
      if (accept) begin
        row_q  <= row_num;
        col_q  <= col_num;
        char_q <= char_code;
        fg_q   <= fg_color;
        bg_q   <= bg_color;
      end
      if (state == FETCH) begin
        addr_q  <= ADDR_BITS'((ORIGIN_Y + int'(row_q) * CHAR_HEIGHT) * SCREEN_WIDTH
                              + int'(col_q) * CHAR_WIDTH);
        px      <= '0;
        bit_idx <= IDX_W'(GLYPH_BITS - 1);
      end else if (state == DRAW) begin
        bit_idx <= bit_idx - IDX_W'(1);
        if (line_end) begin
          px     <= '0;
          addr_q <= addr_q + LINE_STEP;
        end else begin
          px     <= px + PX_W'(1);
          addr_q <= addr_q + ADDR_BITS'(1);
        end
      end
    end
  end

`ifdef GLYPH_TRANSPARENT_EN
  logic unused_bg;
  assign unused_bg = ^bg_q;
`endif

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    error       = error_q;
    mem_wenable = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    if (state == DRAW) begin
`ifdef GLYPH_TRANSPARENT_EN
      if (pixel_on) begin
        mem_wenable = 1'b1;
        mem_waddr   = addr_q;
        mem_wdata   = fg_q;
      end
`else
      mem_wenable = 1'b1;
      mem_waddr   = addr_q;
      mem_wdata   = pixel_on ? fg_q : bg_q;
`endif
    end
  end

endmodule
